// File: rtl/ucsbece154b_icache_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding and the
// default geometry. Field widths (offset/set/tag) are derived in the modules
// from these parameters so each instance stays self-consistent.
package ucsbece154b_icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } icacheState_t;

    localparam int unsigned DEF_NUM_SETS    = 8;
    localparam int unsigned DEF_NUM_WAYS    = 4;
    localparam int unsigned DEF_BLOCK_WORDS = 4;
    localparam int unsigned WORD_WIDTH      = 32;

endpackage

// File: rtl/ucsbece154b_icache_way.sv
// One way of the instruction cache: valid, tag and data arrays per set.
// Ports: clk/reset (sync, active-high; clears valid bits only),
//   ReadSet_i/ReadOffset_i -> Valid_o/Tag_o/Data_o (asynchronous read),
//   WriteEnable_i/WriteSet_i/WriteTag_i/WriteLine_i (whole-line commit).
module ucsbece154b_icache_way import ucsbece154b_icache_pkg::*; #(
    parameter int unsigned NUM_SETS     = DEF_NUM_SETS,
    parameter int unsigned BLOCK_WORDS  = DEF_BLOCK_WORDS,
    parameter int unsigned SET_WIDTH    = 3,
    parameter int unsigned OFFSET_WIDTH = 2,
    parameter int unsigned TAG_WIDTH    = 25
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [SET_WIDTH-1:0]              ReadSet_i,
    input  logic [OFFSET_WIDTH-1:0]           ReadOffset_i,
    output logic                              Valid_o,
    output logic [TAG_WIDTH-1:0]              Tag_o,
    output logic [WORD_WIDTH-1:0]             Data_o,
    input  logic                              WriteEnable_i,
    input  logic [SET_WIDTH-1:0]              WriteSet_i,
    input  logic [TAG_WIDTH-1:0]              WriteTag_i,
    input  logic [BLOCK_WORDS*WORD_WIDTH-1:0] WriteLine_i
);

    logic [NUM_SETS-1:0]   validQ;
    logic [TAG_WIDTH-1:0]  tagQ  [NUM_SETS];
    logic [WORD_WIDTH-1:0] dataQ [NUM_SETS][BLOCK_WORDS];

    // Valid bits are the only state that must be cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            validQ <= '0;
        end else if (WriteEnable_i) begin
            validQ[WriteSet_i] <= 1'b1;
        end
    end

    // Tag and data storage, written a whole line at a time
    always_ff @(posedge clk) begin
        if (WriteEnable_i) begin
            tagQ[WriteSet_i] <= WriteTag_i;
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                dataQ[WriteSet_i][w] <= WriteLine_i[w*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign Valid_o = validQ[ReadSet_i];
    assign Tag_o   = tagQ[ReadSet_i];
    assign Data_o  = dataQ[ReadSet_i][ReadOffset_i];

endmodule

// File: rtl/ucsbece154b_icache.sv
// Set-associative read-only instruction cache between fetch and memory.
// Hits answer combinationally in IDLE; a miss issues one burst request,
// collects BLOCK_WORDS words into a line buffer and commits the line.
// Ports: clk, reset (sync, active-high); fetch side ReadEnable_i,
//   ReadAddress_i, Flush_i -> Instruction_o, Ready_o, Busy_o; memory side
//   MemReadRequest_o, MemReadAddress_o <- MemDataIn_i, MemDataReady_i.
// Build option ICACHE_EARLY_RESTART_EN: critical-word-first burst with
//   delivery of the requested word as soon as it arrives.
module ucsbece154b_icache import ucsbece154b_icache_pkg::*; #(
    parameter int unsigned NUM_SETS    = DEF_NUM_SETS,
    parameter int unsigned NUM_WAYS    = DEF_NUM_WAYS,
    parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ReadEnable_i,
    input  logic [31:0]           ReadAddress_i,
    input  logic                  Flush_i,
    output logic [WORD_WIDTH-1:0] Instruction_o,
    output logic                  Ready_o,
    output logic                  Busy_o,
    output logic                  MemReadRequest_o,
    output logic [31:0]           MemReadAddress_o,
    input  logic [WORD_WIDTH-1:0] MemDataIn_i,
    input  logic                  MemDataReady_i
);

    localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_WORDS);
    localparam int unsigned SET_WIDTH    = $clog2(NUM_SETS);
    localparam int unsigned TAG_WIDTH    = 32 - 2 - OFFSET_WIDTH - SET_WIDTH;
    localparam int unsigned WAY_WIDTH    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned LINE_WIDTH   = BLOCK_WORDS * WORD_WIDTH;

    icacheState_t state, stateNext;

    logic [OFFSET_WIDTH-1:0] addrOffset, latchOffset, wordCount, fillIdx;
    logic [SET_WIDTH-1:0]    addrSet, latchSet, rdSet;
    logic [TAG_WIDTH-1:0]    addrTag, latchTag;
    logic [31:0]             memAddrQ, missAddr;
    logic                    dropQ;
    logic [WORD_WIDTH-1:0]   lineBuf [BLOCK_WORDS];
    logic [WAY_WIDTH-1:0]    rrPtr   [NUM_SETS];

    logic                    wayValid [NUM_WAYS];
    logic [TAG_WIDTH-1:0]    wayTag   [NUM_WAYS];
    logic [WORD_WIDTH-1:0]   wayData  [NUM_WAYS];
    logic [NUM_WAYS-1:0]     wayWrite;

    logic                    hitAny, lookupHit, missStart, wordArrive, lastWord;
    logic                    earlyReady, invalidFound;
    logic [WAY_WIDTH-1:0]    victimWay;
    logic [WORD_WIDTH-1:0]   hitData;
    logic [LINE_WIDTH-1:0]   commitLine;
    logic                    unusedAddrBits;

    assign addrOffset     = ReadAddress_i[2 +: OFFSET_WIDTH];
    assign addrSet        = ReadAddress_i[2+OFFSET_WIDTH +: SET_WIDTH];
    assign addrTag        = ReadAddress_i[31 -: TAG_WIDTH];
    assign unusedAddrBits = &{1'b0, ReadAddress_i[1:0], latchOffset};

    // Outside IDLE the arrays are only needed for victim choice in the miss set
    assign rdSet = (state == IDLE) ? addrSet : latchSet;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        ucsbece154b_icache_way #(
            .NUM_SETS    (NUM_SETS),
            .BLOCK_WORDS (BLOCK_WORDS),
            .SET_WIDTH   (SET_WIDTH),
            .OFFSET_WIDTH(OFFSET_WIDTH),
            .TAG_WIDTH   (TAG_WIDTH)
        ) u_way (
            .clk          (clk),
            .reset        (reset),
            .ReadSet_i    (rdSet),
            .ReadOffset_i (addrOffset),
            .Valid_o      (wayValid[w]),
            .Tag_o        (wayTag[w]),
            .Data_o       (wayData[w]),
            .WriteEnable_i(wayWrite[w]),
            .WriteSet_i   (latchSet),
            .WriteTag_i   (latchTag),
            .WriteLine_i  (commitLine)
        );
    end

    // Parallel tag compare across the selected set
    always_comb begin
        hitAny  = 1'b0;
        hitData = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (wayValid[w] && (wayTag[w] == addrTag)) begin
                hitAny  = 1'b1;
                hitData = wayData[w];
            end
        end
    end

    assign lookupHit  = ReadEnable_i && (state == IDLE) && hitAny;
    assign missStart  = ReadEnable_i && (state == IDLE) && !hitAny;
    assign wordArrive = (state == FILL) && MemDataReady_i;
    assign lastWord   = wordArrive && (wordCount == OFFSET_WIDTH'(BLOCK_WORDS - 1));

`ifdef ICACHE_EARLY_RESTART_EN
    // Burst wraps from the critical word, so its slot is offset + count
    assign fillIdx    = latchOffset + wordCount;
    assign missAddr   = {addrTag, addrSet, addrOffset, 2'b00};
    assign earlyReady = wordArrive && (wordCount == '0) && !dropQ && !Flush_i &&
                        ReadEnable_i &&
                        ({addrTag, addrSet, addrOffset} == {latchTag, latchSet, latchOffset});
`else
    assign fillIdx    = wordCount;
    assign missAddr   = {addrTag, addrSet, OFFSET_WIDTH'(0), 2'b00};
    assign earlyReady = 1'b0;
`endif

    // Line image committed on the final beat, which bypasses the buffer
    always_comb begin
        commitLine = '0;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            commitLine[w*WORD_WIDTH +: WORD_WIDTH] =
                (OFFSET_WIDTH'(w) == fillIdx) ? MemDataIn_i : lineBuf[w];
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        invalidFound = 1'b0;
        victimWay    = rrPtr[latchSet];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!wayValid[w]) begin
                invalidFound = 1'b1;
                victimWay    = WAY_WIDTH'(w);
            end
        end
        wayWrite = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            wayWrite[w] = lastWord && (victimWay == WAY_WIDTH'(w));
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (missStart) stateNext = REQ;
            REQ:     stateNext = FILL;
            FILL:    if (lastWord) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register and miss bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wordCount   <= '0;
            dropQ       <= 1'b0;
            memAddrQ    <= '0;
            latchTag    <= '0;
            latchSet    <= '0;
            latchOffset <= '0;
            for (int s = 0; s < NUM_SETS; s++) rrPtr[s] <= '0;
        end else begin
            state <= stateNext;
            if (missStart) begin
                latchTag    <= addrTag;
                latchSet    <= addrSet;
                latchOffset <= addrOffset;
                memAddrQ    <= missAddr;
            end
            if (wordArrive) begin
                wordCount <= lastWord ? '0 : wordCount + OFFSET_WIDTH'(1);
            end
            if (lastWord) begin
                dropQ <= 1'b0;
            end else if ((state != IDLE) && Flush_i) begin
                dropQ <= 1'b1;
            end
            if (lastWord && !invalidFound) begin
                rrPtr[latchSet] <= (rrPtr[latchSet] == WAY_WIDTH'(NUM_WAYS - 1)) ?
                                   '0 : rrPtr[latchSet] + WAY_WIDTH'(1);
            end
        end
    end

    // Line buffer capture
    always_ff @(posedge clk) begin
        if (wordArrive) lineBuf[fillIdx] <= MemDataIn_i;
    end

    assign Ready_o          = !reset && (lookupHit || earlyReady);
    assign Instruction_o    = reset      ? '0 :
                              lookupHit  ? hitData :
                              earlyReady ? MemDataIn_i : '0;
    assign Busy_o           = ReadEnable_i && !Ready_o;
    assign MemReadRequest_o = !reset && (state == REQ);
    assign MemReadAddress_o = reset ? '0 : memAddrQ;

endmodule

// File: tb/tb_ucsbece154b_icache.sv
`timescale 1ns/1ps
module tb_ucsbece154b_icache;

    localparam int unsigned BW = 4;
    localparam int unsigned NS = 8;
    localparam int unsigned NW = 4;
`ifdef ICACHE_EARLY_RESTART_EN
    localparam bit ER = 1'b1;
`else
    localparam bit ER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ReadEnable_i = 1'b0;
    logic [31:0] ReadAddress_i = '0;
    logic        Flush_i = 1'b0;
    logic [31:0] Instruction_o;
    logic        Ready_o, Busy_o, MemReadRequest_o;
    logic [31:0] MemReadAddress_o;
    logic [31:0] MemDataIn_i = '0;
    logic        MemDataReady_i = 1'b0;

    always #5 clk = ~clk;

    ucsbece154b_icache #(.NUM_SETS(NS), .NUM_WAYS(NW), .BLOCK_WORDS(BW)) dut (
        .clk(clk), .reset(reset),
        .ReadEnable_i(ReadEnable_i), .ReadAddress_i(ReadAddress_i), .Flush_i(Flush_i),
        .Instruction_o(Instruction_o), .Ready_o(Ready_o), .Busy_o(Busy_o),
        .MemReadRequest_o(MemReadRequest_o), .MemReadAddress_o(MemReadAddress_o),
        .MemDataIn_i(MemDataIn_i), .MemDataReady_i(MemDataReady_i)
    );

    int nChecks = 0;
    int nFails  = 0;
    logic [31:0] scoreQ[$];
    logic [31:0] reqQ[$];
    int reqCount  = 0;
    int wordsSent = 0;
    bit respBusy  = 1'b0;
    bit fastMem   = 1'b1;

    // Reference cache state: tags per set/way plus replacement pointer
    bit          mValid [NS][NW];
    logic [31:0] mTag   [NS][NW];
    int          mRr    [NS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a[31:4] == 28'h0001000) return 32'hA0 + {28'd0, a[3:2]};
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int setOf(input logic [31:0] a);
        return int'((a / (BW * 4)) % NS);
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] a);
        return a / (BW * 4 * NS);
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        for (int w = 0; w < NW; w++)
            if (mValid[setOf(a)][w] && mTag[setOf(a)][w] == tagOf(a)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelInstall(input logic [31:0] a);
        int s;
        int v;
        s = setOf(a);
        v = -1;
        for (int w = 0; w < NW; w++) if (!mValid[s][w] && v < 0) v = w;
        if (v < 0) begin
            v = mRr[s];
            mRr[s] = (mRr[s] + 1) % NW;
        end
        mValid[s][v] = 1'b1;
        mTag[s][v]   = tagOf(a);
    endtask

    task automatic modelReset();
        for (int s = 0; s < NS; s++) begin
            mRr[s] = 0;
            for (int w = 0; w < NW; w++) mValid[s][w] = 1'b0;
        end
    endtask

    function automatic logic [31:0] expReqAddr(input logic [31:0] a);
        if (ER) return a & ~32'h3;
        return a & ~32'(BW * 4 - 1);
    endfunction

    // Monitor: every Ready_o cycle consumes one expected instruction
    always @(negedge clk) begin
        if (Ready_o === 1'b1) begin
            if (scoreQ.size() == 0) check("spurious_ready", 32'(Ready_o), 32'd0);
            else check("instruction", Instruction_o, scoreQ.pop_front());
        end
    end

    // Memory responder: serves each request with BW beats in the expected order
    initial begin : responder
        logic [31:0] exp;
        logic [31:0] base;
        int startOff;
        int gap;
        int idx;
        forever begin
            @(negedge clk);
            if (MemReadRequest_o === 1'b1) begin
                reqCount++;
                if (reqQ.size() == 0) begin
                    check("spurious_request", 32'(MemReadRequest_o), 32'd0);
                    exp = MemReadAddress_o;
                end else begin
                    exp = reqQ.pop_front();
                    check("mem_req_addr", MemReadAddress_o, exp);
                end
                respBusy  = 1'b1;
                wordsSent = 0;
                base      = exp & ~32'(BW * 4 - 1);
                startOff  = ER ? int'((exp / 4) % BW) : 0;
                @(posedge clk); #1;
                for (int k = 0; k < BW; k++) begin
                    gap = fastMem ? 0 : int'($urandom_range(0, 2));
                    MemDataReady_i = 1'b0;
                    repeat (gap) begin @(posedge clk); #1; end
                    idx = (startOff + k) % BW;
                    MemDataIn_i    = memWord(base + 32'(idx * 4));
                    MemDataReady_i = 1'b1;
                    wordsSent++;
                    @(posedge clk); #1;
                end
                MemDataReady_i = 1'b0;
                respBusy       = 1'b0;
            end
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        while (respBusy && n < 200) begin @(posedge clk); #2; n++; end
        if (respBusy) check("fill_done", 32'(respBusy), 32'd0);
    endtask

    task automatic waitWords(input int k);
        int n;
        n = 0;
        while (!(respBusy && wordsSent >= k) && n < 200) begin @(posedge clk); #2; n++; end
        if (n >= 200) check("words_timeout", 32'(wordsSent), 32'(k));
    endtask

    task automatic doReset();
        @(posedge clk); #2;
        reset = 1'b1; ReadEnable_i = 1'b0; Flush_i = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        modelReset();
    endtask

    // One fetch: predicts hit/miss, queues expectations, waits for Ready_o
    task automatic fetch(input logic [31:0] a);
        bit hit;
        bit got;
        int cyc;
        int reqBefore;
        int expLat;
        hit = modelHit(a);
        scoreQ.push_back(memWord(a & ~32'h3));
        if (!hit) begin
            reqQ.push_back(expReqAddr(a));
            modelInstall(a);
        end
        expLat = hit ? 0 : (ER ? 2 : 2 + int'(BW));
        @(posedge clk); #2;
        reqBefore = reqCount;
        ReadEnable_i = 1'b1; ReadAddress_i = a;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            if (Ready_o === 1'b1) got = 1'b1;
            else begin
                if (cyc == 0) check("busy_on_miss", 32'(Busy_o), 32'd1);
                cyc++;
            end
        end
        check("ready_seen", 32'(got), 32'd1);
        if (got && (hit || fastMem)) check("latency", 32'(cyc), 32'(expLat));
        check("request_count", 32'(reqCount - reqBefore), hit ? 32'd0 : 32'd1);
        @(posedge clk); #2;
        ReadEnable_i = 1'b0;
        waitIdle();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] a;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(Ready_o), 32'd0);
        check("reset_memreq", 32'(MemReadRequest_o), 32'd0);
        check("reset_memaddr", MemReadAddress_o, 32'd0);
        check("reset_instr", Instruction_o, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // Cold miss then same-line hit
        fastMem = 1'b1;
        fetch(32'h0001_0000);
        fetch(32'h0001_0008);

        // Mid-line miss: request address and delivery depend on early restart
        doReset();
        fetch(32'h0001_0008);
        fetch(32'h0001_000C);

        // Gating: no fetch request means no miss
        doReset();
        ReadAddress_i = 32'h0002_0000;
        repeat (5) begin
            @(negedge clk);
            check("gate_memreq", 32'(MemReadRequest_o), 32'd0);
            check("gate_busy", 32'(Busy_o), 32'd0);
        end

        // Conflict set 0: fifth fill evicts way 0
        fetch(32'h0000_0000);
        fetch(32'h0000_0080);
        fetch(32'h0000_0100);
        fetch(32'h0000_0180);
        fetch(32'h0000_0200);
        fetch(32'h0000_0080);
        fetch(32'h0000_0000);

        // Flush mid-fill: line still installed, no late delivery
        a = 32'h0003_0004;
        reqQ.push_back(expReqAddr(a));
        modelInstall(a);
        if (ER) scoreQ.push_back(memWord(a));
        @(posedge clk); #2;
        ReadEnable_i = 1'b1; ReadAddress_i = a;
        waitWords(2);
        Flush_i = 1'b1; ReadEnable_i = 1'b0;
        @(posedge clk); #2;
        Flush_i = 1'b0;
        waitIdle();
        repeat (2) @(posedge clk);
        fetch(a);

        // Reset mid-fill: residual beats ignored, line not installed
        a = 32'h0004_0000;
        reqQ.push_back(expReqAddr(a));
        if (ER) scoreQ.push_back(memWord(a));
        @(posedge clk); #2;
        ReadEnable_i = 1'b1; ReadAddress_i = a;
        waitWords(2);
        reset = 1'b1; ReadEnable_i = 1'b0;
        @(negedge clk);
        check("rst_fill_memreq", 32'(MemReadRequest_o), 32'd0);
        check("rst_fill_ready", 32'(Ready_o), 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        modelReset();
        waitIdle();
        repeat (2) begin
            @(negedge clk);
            check("post_rst_memreq", 32'(MemReadRequest_o), 32'd0);
            check("post_rst_memaddr", MemReadAddress_o, 32'd0);
        end
        fetch(a);

        // Randomized traffic over a conflict-heavy address pool
        fastMem = 1'b0;
        for (int i = 0; i < 120; i++) begin
            a = 32'h0001_0000 + 32'($urandom_range(0, 5)) * 32'h80
              + 32'($urandom_range(0, NS - 1)) * 32'h10
              + 32'($urandom_range(0, BW - 1)) * 32'h4;
            fetch(a);
        end

        repeat (3) @(posedge clk);
        check("score_empty", 32'(scoreQ.size()), 32'd0);
        check("req_empty", 32'(reqQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
